// File: rtl/codec_i2s_intf_if.sv
// Bundle of the codec-side I2S pins and the equalizer-core sample bus.
//   master : the I2S boundary stage (drives codec clocks, reset, DAC data and
//            the captured ADC samples; receives ADC data and core samples)
//   slave  : codec + core side (drives SDout, lft_out, rht_out)
// Signals:
//   SDout          serial ADC data from codec
//   lft_out/rht_out 16-bit samples from core, to DAC
//   MCLK/SCLK/LRCLK codec master, bit and word-select clocks
//   RSTn           codec reset, active low
//   SDin           serial DAC data to codec
//   lft_in/rht_in  captured ADC samples, valid = one-clk update strobe
interface codec_i2s_intf_if;
    logic        SDout;
    logic [15:0] lft_out;
    logic [15:0] rht_out;
    logic        MCLK;
    logic        SCLK;
    logic        LRCLK;
    logic        RSTn;
    logic        SDin;
    logic [15:0] lft_in;
    logic [15:0] rht_in;
    logic        valid;

    modport master (
        input  SDout, lft_out, rht_out,
        output MCLK, SCLK, LRCLK, RSTn, SDin, lft_in, rht_in, valid
    );

    modport slave (
        output SDout, lft_out, rht_out,
        input  MCLK, SCLK, LRCLK, RSTn, SDin, lft_in, rht_in, valid
    );
endinterface

// File: rtl/codec_i2s_intf.sv
// I2S boundary stage between the audio codec and the equalizer core.
// A 10-bit free-running counter produces MCLK (clk/4), SCLK (clk/32) and
// LRCLK (clk/1024, 0 = left). 16-bit I2S words, one-bit delay, MSB first.
// ADC words are deserialized into lft_in/rht_in with a one-clk valid strobe;
// lft_out/rht_out are serialized onto SDin. The codec is held in reset for
// one frame, then one partial frame is discarded before valid starts.
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  codec_i2s_intf_if.master (codec pins + core sample bus)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// RST_CODEC | codec held in reset (RSTn = 0) for the first counter pass
// SYNC      | codec released, waiting out the partial first frame
// RUN       | normal operation, valid strobes once per frame
module codec_i2s_intf (
    input  logic             clk,
    input  logic             rst,
    codec_i2s_intf_if.master bus
);

    typedef enum logic [1:0] {
        RST_CODEC = 2'd0,
        SYNC      = 2'd1,
        RUN       = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  cnt_q, cnt_d;
    logic        rstn_q, rstn_d;
    logic        valid_q, valid_d;
    logic [15:0] rx_shft_q, rx_shft_d;
    logic [15:0] lft_hold_q, lft_hold_d;
    logic [15:0] lft_in_q, lft_in_d;
    logic [15:0] rht_in_q, rht_in_d;
    logic [15:0] tx_shft_q, tx_shft_d;
    logic [15:0] rht_hold_q, rht_hold_d;

    logic        sclk_rise;
    logic        sclk_fall;
    logic [15:0] rx_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RST_CODEC;
            cnt_q      <= '0;
            rstn_q     <= 1'b0;
            valid_q    <= 1'b0;
            rx_shft_q  <= '0;
            lft_hold_q <= '0;
            lft_in_q   <= '0;
            rht_in_q   <= '0;
            tx_shft_q  <= '0;
            rht_hold_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rstn_q     <= rstn_d;
            valid_q    <= valid_d;
            rx_shft_q  <= rx_shft_d;
            lft_hold_q <= lft_hold_d;
            lft_in_q   <= lft_in_d;
            rht_in_q   <= rht_in_d;
            tx_shft_q  <= tx_shft_d;
            rht_hold_q <= rht_hold_d;
        end
    end

    always_comb begin
        cnt_d      = cnt_q + 10'd1;
        state_d    = state_q;
        valid_d    = 1'b0;
        rx_shft_d  = rx_shft_q;
        lft_hold_d = lft_hold_q;
        lft_in_d   = lft_in_q;
        rht_in_d   = rht_in_q;
        tx_shft_d  = tx_shft_q;
        rht_hold_d = rht_hold_q;

        // Decodes fire in the cycle before SCLK changes, so the effect lands
        // exactly on the SCLK edge.
        sclk_rise = (cnt_q[4:0] == 5'h0F);
        sclk_fall = (cnt_q[4:0] == 5'h1F);
        rx_word   = {rx_shft_q[14:0], bus.SDout};

        case (state_q)
            RST_CODEC: if (cnt_q == 10'h3FF) state_d = SYNC;
            SYNC:      if (cnt_q == 10'h00F) state_d = RUN;
            RUN:       state_d = RUN;
            default:   state_d = RST_CODEC;
        endcase

        // Registered so the codec reset pin never glitches on state changes.
        rstn_d  = (state_d != RST_CODEC);
        // The SYNC->RUN transition cycle is excluded: that frame is partial.
        valid_d = (state_q == RUN) && (cnt_q == 10'h00F);

        if (sclk_rise) begin
            rx_shft_d = rx_word;
            if (cnt_q == 10'h20F) begin
                lft_hold_d = rx_word;
            end
            if (cnt_q == 10'h00F) begin
                rht_in_d = rx_word;
                lft_in_d = lft_hold_q;
            end
        end

        if (sclk_fall) begin
            if (cnt_q == 10'h01F) begin
                // Both channels sampled together so the DAC pair is coherent.
                tx_shft_d  = bus.lft_out;
                rht_hold_d = bus.rht_out;
            end else if (cnt_q == 10'h21F) begin
                tx_shft_d = rht_hold_q;
            end else begin
                tx_shft_d = {tx_shft_q[14:0], 1'b0};
            end
        end
    end

    assign bus.MCLK   = cnt_q[1];
    assign bus.SCLK   = cnt_q[4];
    assign bus.LRCLK  = cnt_q[9];
    assign bus.RSTn   = rstn_q;
    assign bus.SDin   = tx_shft_q[15];
    assign bus.lft_in = lft_in_q;
    assign bus.rht_in = rht_in_q;
    assign bus.valid  = valid_q;

endmodule

// File: tb/tb_codec_i2s_intf.sv
module tb_codec_i2s_intf;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    codec_i2s_intf_if bus();

    codec_i2s_intf dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [15:0] sd_l;
        logic [15:0] sd_r;
        logic [15:0] core_l;
        logic [15:0] core_r;
        logic [15:0] exp_in_l;
        logic [15:0] exp_in_r;
        logic [15:0] exp_tx_l;
        logic [15:0] exp_tx_r;
    } vec_t;

    vec_t tv [4];

    int errors = 0;
    int checks = 0;

    // clk edges since rst release; the model derives everything from this
    int          k;
    logic [15:0] sd_l [64];
    logic [15:0] sd_r [64];
    logic [15:0] fix_sd_l, fix_sd_r;
    bit          rand_codec, rand_core, loopback, tx_armed;
    int          chg_pt;
    logic [15:0] cap_l, cap_r;
    logic [15:0] recon, last_tx_l, last_tx_r;
    logic [15:0] prev_exp_l, prev_exp_r;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (k=%0d)", name, act, exp, k);
            if (errors >= 40) begin
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
        end
    endtask

    task automatic model_cycle();
        int c, f, half, slot;
        logic [15:0] w;
        logic [2:0]  clk_exp;
        c    = k % 1024;
        f    = k / 1024;
        half = c / 512;
        slot = (c % 512) / 32;

        clk_exp[2] = ((k / 2) % 2) == 1;
        clk_exp[1] = ((k / 16) % 2) == 1;
        clk_exp[0] = ((k / 512) % 2) == 1;
        chk("clocks", {bus.MCLK, bus.SCLK, bus.LRCLK}, clk_exp);
        chk("rstn", bus.RSTn, k >= 1024);
        chk("valid", bus.valid, (k >= 2064) && ((k - 2064) % 1024 == 0));

        if (k >= 2064 && c == 16) begin
            prev_exp_l = sd_l[(f - 1) % 64];
            prev_exp_r = sd_r[(f - 1) % 64];
            chk("rx_lft", bus.lft_in, prev_exp_l);
            chk("rx_rht", bus.rht_in, prev_exp_r);
        end
        if (k >= 2064 + 1023 && c == 15) begin
            chk("rx_lft_stable", bus.lft_in, prev_exp_l);
            chk("rx_rht_stable", bus.rht_in, prev_exp_r);
        end

        // codec DAC side: sample SDin while SCLK rises
        if (c % 32 == 15) begin
            recon = {recon[14:0], bus.SDin};
            if (c == 'h20F) begin
                chk("tx_lft", recon, cap_l);
                last_tx_l = recon;
            end
            if (c == 'h00F && tx_armed) begin
                chk("tx_rht", recon, cap_r);
                last_tx_r = recon;
            end
        end

        if (c == 0) begin
            chg_pt = $urandom_range(0, 1023);
            if (!loopback) begin
                sd_l[f % 64] = rand_codec ? 16'($urandom) : fix_sd_l;
                sd_r[f % 64] = rand_codec ? 16'($urandom) : fix_sd_r;
            end
        end
        if (rand_core && c == chg_pt) bus.lft_out = 16'($urandom);
        if (rand_core && (c == chg_pt || c == 256)) bus.rht_out = 16'($urandom);

        if (loopback) begin
            bus.SDout = bus.SDin;
        end else if (slot == 0) begin
            w = (half == 0) ? sd_r[(f + 63) % 64] : sd_l[f % 64];
            bus.SDout = w[0];
        end else begin
            w = (half == 0) ? sd_l[f % 64] : sd_r[f % 64];
            bus.SDout = w[16 - slot];
        end

        if (c == 'h01F) begin
            cap_l    = bus.lft_out;
            cap_r    = bus.rht_out;
            tx_armed = 1'b1;
            if (loopback) begin
                sd_l[f % 64] = cap_l;
                sd_r[f % 64] = cap_r;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        k++;
        @(negedge clk);
        model_cycle();
    endtask

    task automatic run_to(input int target);
        for (int i = 0; i < 1024 && (k % 1024) != target; i++) step();
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_clocks"}, {bus.MCLK, bus.SCLK, bus.LRCLK}, 3'b000);
        chk({tag, "_rstn"}, bus.RSTn, 1'b0);
        chk({tag, "_valid"}, bus.valid, 1'b0);
        chk({tag, "_lft_in"}, bus.lft_in, 16'h0000);
        chk({tag, "_rht_in"}, bus.rht_in, 16'h0000);
        chk({tag, "_sdin"}, bus.SDin, 1'b0);
    endtask

    task automatic release_reset();
        rst      = 1'b0;
        k        = 0;
        tx_armed = 1'b0;
        recon    = '0;
        model_cycle();
    endtask

    initial begin
        tv[0] = '{16'h8001, 16'h7FFE, 16'hA5C3, 16'h0F0F, 16'h8001, 16'h7FFE, 16'hA5C3, 16'h0F0F};
        tv[1] = '{16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF};
        tv[2] = '{16'h0001, 16'h8000, 16'h8000, 16'h0001, 16'h0001, 16'h8000, 16'h8000, 16'h0001};
        tv[3] = '{16'hAAAA, 16'h5555, 16'h1357, 16'hFDB9, 16'hAAAA, 16'h5555, 16'h1357, 16'hFDB9};

        for (int i = 0; i < 64; i++) begin
            sd_l[i] = '0;
            sd_r[i] = '0;
        end
        fix_sd_l    = '0;
        fix_sd_r    = '0;
        rand_codec  = 1'b0;
        rand_core   = 1'b0;
        loopback    = 1'b0;
        cap_l       = '0;
        cap_r       = '0;
        last_tx_l   = '0;
        last_tx_r   = '0;
        prev_exp_l  = '0;
        prev_exp_r  = '0;
        k           = 0;
        bus.SDout   = 1'b0;
        bus.lft_out = '0;
        bus.rht_out = '0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        reset_checks("por");
        release_reset();

        // fixed-pattern vectors; the first one also spans startup
        for (int i = 0; i < 4; i++) begin
            run_to(1023);
            fix_sd_l    = tv[i].sd_l;
            fix_sd_r    = tv[i].sd_r;
            bus.lft_out = tv[i].core_l;
            bus.rht_out = tv[i].core_r;
            repeat (1042) step();
            chk("vec_lft_in", bus.lft_in, tv[i].exp_in_l);
            chk("vec_rht_in", bus.rht_in, tv[i].exp_in_r);
            chk("vec_tx_lft", last_tx_l, tv[i].exp_tx_l);
            chk("vec_tx_rht", last_tx_r, tv[i].exp_tx_r);
        end

        // coherence: a late rht_out change must wait for the next frame
        run_to(1023);
        bus.lft_out = 16'hA5C3;
        bus.rht_out = 16'h0F0F;
        run_to(256);
        bus.rht_out = 16'h1234;
        run_to(17);
        chk("coh_old_rht", last_tx_r, 16'h0F0F);
        chk("coh_lft", last_tx_l, 16'hA5C3);
        step();
        run_to(17);
        chk("coh_new_rht", last_tx_r, 16'h1234);

        rand_codec = 1'b1;
        rand_core  = 1'b1;
        repeat (20 * 1024) step();
        rand_codec = 1'b0;
        rand_core  = 1'b0;

        // loopback: SDin fed straight back to SDout
        run_to(16);
        loopback    = 1'b1;
        bus.lft_out = 16'h1357;
        bus.rht_out = 16'hFDB9;
        repeat (1025) step();
        chk("loop_lft_in", bus.lft_in, 16'h1357);
        chk("loop_rht_in", bus.rht_in, 16'hFDB9);
        repeat (1024) step();
        chk("loop_lft_in2", bus.lft_in, 16'h1357);
        chk("loop_rht_in2", bus.rht_in, 16'hFDB9);
        loopback = 1'b0;

        // reset mid-frame, then startup again with random traffic
        run_to('h123);
        rst = 1'b1;
        #1;
        reset_checks("mid");
        repeat (2) @(negedge clk);
        reset_checks("hold");
        rand_codec = 1'b1;
        rand_core  = 1'b1;
        release_reset();
        repeat (2100) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
